// File: rtl/prm_edge_mask_engine.sv
// prm_edge_mask_engine
//   Run-time loadable cube table that turns a quantised arm-configuration code
//   into a per-edge "blocked" mask. Each row holds a care mask, a value and an
//   edge tag. A row matches when the code agrees with the value on every care
//   bit. Matching rows set their edge bit in the result.
//   Rows 0..cube_count-1 are scanned one per cycle after a query is accepted.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cfg_we/addr/care/val/edge   cube row write (accepted only while idle)
//   cfg_cnt_we/cfg_cnt          active cube count load (0..MAX_CUBES)
//   cfg_err                     one-cycle pulse when a cfg write is rejected
//   cube_count                  current active cube count
//   q_valid/q_ready/q_code      query handshake
//   r_valid/r_ready/r_mask      result handshake, mask held until consumed
//   busy                        engine is scanning or holding a result
module prm_edge_mask_engine #(
  parameter int IN_W      = 15,
  parameter int NUM_EDGES = 8,
  parameter int MAX_CUBES = 256,
  parameter int EDGE_W    = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1,
  parameter int CA_W      = $clog2(MAX_CUBES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [CA_W-1:0]      cfg_addr,
  input  logic [IN_W-1:0]      cfg_care,
  input  logic [IN_W-1:0]      cfg_val,
  input  logic [EDGE_W-1:0]    cfg_edge,
  input  logic                 cfg_cnt_we,
  input  logic [CA_W:0]        cfg_cnt,
  output logic                 cfg_err,
  output logic [CA_W:0]        cube_count,
  input  logic                 q_valid,
  output logic                 q_ready,
  input  logic [IN_W-1:0]      q_code,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [NUM_EDGES-1:0] r_mask,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  typedef struct packed {
    logic [IN_W-1:0]   care;
    logic [IN_W-1:0]   val;
    logic [EDGE_W-1:0] edge_tag;
  } cube_t;

  localparam logic [CA_W:0] MAX_CNT = (CA_W+1)'(MAX_CUBES);

  // Table is deliberately not reset: a reset aborts queries but keeps the rows.
  cube_t cube_mem [MAX_CUBES];

  state_t              state_q, state_d;
  logic [IN_W-1:0]     code_q, code_d;
  logic [NUM_EDGES-1:0] acc_q, acc_d;
  logic [CA_W-1:0]     idx_q, idx_d;
  logic [CA_W:0]       cnt_q, cnt_d;
  logic                err_q, err_d;

  logic  idle;
  logic  tbl_we;
  cube_t row;
  logic  row_hit;

  assign idle   = (state_q == S_IDLE);
  assign tbl_we = idle && cfg_we;

  always_comb begin
    row     = cube_mem[idx_q];
    row_hit = ((code_q ^ row.val) & row.care) == '0;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (idle) begin
      if (cfg_cnt_we) begin
        if (cfg_cnt <= MAX_CNT) cnt_d = cfg_cnt;
        else                    err_d = 1'b1;
      end
      // Decision uses cnt_d so a count loaded in the accept cycle is honoured.
      if (q_valid) begin
        code_d  = q_code;
        acc_d   = '0;
        idx_d   = '0;
        state_d = (cnt_d != '0) ? S_SCAN : S_DONE;
      end
    end else begin
      err_d = cfg_we || cfg_cnt_we;
    end
    case (state_q)
      S_SCAN: begin
        // Tags beyond the edge range are evaluated but ignored.
        if (row_hit && (int'(row.edge_tag) < NUM_EDGES)) acc_d[row.edge_tag] = 1'b1;
        idx_d = idx_q + CA_W'(1);
        if ({1'b0, idx_q} == cnt_q - (CA_W+1)'(1)) state_d = S_DONE;
      end
      S_DONE: if (r_ready) state_d = S_IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && tbl_we) cube_mem[cfg_addr] <= {cfg_care, cfg_val, cfg_edge};
  end

  assign q_ready    = idle;
  assign busy       = !idle;
  assign r_valid    = (state_q == S_DONE);
  assign r_mask     = r_valid ? acc_q : '0;
  assign cfg_err    = err_q;
  assign cube_count = cnt_q;

endmodule
